// File: rtl/vector_fetch_unit.sv
// vector_fetch_unit: cache-fronted vector fetch that refills misses from memory and returns the record
module vector_fetch_unit #(
  parameter int EMBEDDING_DIM = 384,
  parameter logic [31:0] VEC_BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] REC_BYTES = 32'((EMBEDDING_DIM + 1) * 4)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic [31:0] req_idx,
  output logic [31:0] cache_lookup_idx,
  input  logic cache_hit,
  input  logic [EMBEDDING_DIM*32-1:0] cache_vector,
  input  logic [31:0] cache_doc_idx,
  output logic cache_store,
  output logic [31:0] cache_store_idx,
  output logic [EMBEDDING_DIM*32-1:0] cache_store_vector,
  output logic [31:0] cache_store_doc_idx,
  output logic mem_rd_valid,
  input  logic mem_rd_ready,
  output logic [31:0] mem_rd_addr,
  input  logic mem_rsp_valid,
  output logic mem_rsp_ready,
  input  logic [31:0] mem_rsp_data,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [31:0] rsp_idx,
  output logic [EMBEDDING_DIM*32-1:0] rsp_vector,
  output logic [31:0] rsp_doc_idx,
  output logic rsp_from_cache,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int BW = $clog2(EMBEDDING_DIM + 1);
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_DATA, STORE, RESP} state_t;
  state_t state;
  logic [31:0] idx_q, doc_q;
  logic [EMBEDDING_DIM*32-1:0] vec_q;
  logic [BW-1:0] beat;
  assign cache_lookup_idx = idx_q;
  assign cache_store_idx = idx_q;
  assign rsp_idx = idx_q;
  assign cache_store_vector = vec_q;
  assign rsp_vector = vec_q;
  assign cache_store_doc_idx = doc_q;
  assign rsp_doc_idx = doc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      idx_q <= '0;
      doc_q <= '0;
      vec_q <= '0;
      beat <= '0;
      mem_rd_valid <= 1'b0;
      mem_rd_addr <= '0;
      mem_rsp_ready <= 1'b0;
      cache_store <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_from_cache <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      cache_store <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          idx_q <= req_idx;
          req_ready <= 1'b0;
          state <= LOOKUP;
        end
        LOOKUP: if (cache_hit) begin
          vec_q <= cache_vector;
          doc_q <= cache_doc_idx;
          rsp_from_cache <= 1'b1;
          rsp_valid <= 1'b1;
          hit_count <= hit_count + 32'(hit_count != '1);
          state <= RESP;
        end else begin
          miss_count <= miss_count + 32'(miss_count != '1);
          beat <= '0;
          mem_rd_valid <= 1'b1;
          mem_rd_addr <= VEC_BASE_ADDR + idx_q * REC_BYTES;
          state <= MEM_REQ;
        end
        MEM_REQ: if (mem_rd_ready) begin
          mem_rd_valid <= 1'b0;
          mem_rsp_ready <= 1'b1;
          state <= MEM_DATA;
        end
        MEM_DATA: if (mem_rsp_valid) begin
          if (beat == '0) doc_q <= mem_rsp_data;
          else vec_q <= {mem_rsp_data, vec_q[EMBEDDING_DIM*32-1:32]};
          beat <= beat + BW'(1);
          if (beat == BW'(EMBEDDING_DIM)) begin
            mem_rsp_ready <= 1'b0;
            cache_store <= 1'b1;
            rsp_from_cache <= 1'b0;
            state <= STORE;
          end
        end
        STORE: begin
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vector_fetch_unit.sv
// tb_vector_fetch_unit: directed and randomized transactions against a cache/memory reference model
module tb_vector_fetch_unit;
  localparam int D = 4;
  localparam logic [31:0] BASE = 32'h1000;
  localparam logic [31:0] REC = 32'((D + 1) * 4);
  logic clk, rst_n, req_valid, req_ready, cache_hit, cache_store, mem_rd_valid, mem_rd_ready;
  logic mem_rsp_valid, mem_rsp_ready, rsp_valid, rsp_ready, rsp_from_cache;
  logic [31:0] req_idx, cache_lookup_idx, cache_doc_idx, cache_store_idx, cache_store_doc_idx;
  logic [31:0] mem_rd_addr, mem_rsp_data, rsp_idx, rsp_doc_idx, hit_count, miss_count;
  logic [D*32-1:0] cache_vector, cache_store_vector, rsp_vector;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_hit = 0;
  logic [31:0] m_miss = 0;
  logic [31:0] c_doc [logic [31:0]];
  logic [D*32-1:0] c_vec [logic [31:0]];
  vector_fetch_unit #(.EMBEDDING_DIM(D), .VEC_BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .cache_lookup_idx(cache_lookup_idx), .cache_hit(cache_hit), .cache_vector(cache_vector),
    .cache_doc_idx(cache_doc_idx), .cache_store(cache_store), .cache_store_idx(cache_store_idx),
    .cache_store_vector(cache_store_vector), .cache_store_doc_idx(cache_store_doc_idx),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx), .rsp_vector(rsp_vector),
    .rsp_doc_idx(rsp_doc_idx), .rsp_from_cache(rsp_from_cache), .hit_count(hit_count),
    .miss_count(miss_count)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_outputs_zero"}, {cache_lookup_idx, cache_store, cache_store_idx, cache_store_vector,
        cache_store_doc_idx, mem_rd_valid, mem_rd_addr, mem_rsp_ready, rsp_valid, rsp_idx, rsp_vector,
        rsp_doc_idx, rsp_from_cache, hit_count, miss_count}, 0);
  endtask
  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == '1) ? v : v + 1;
  endfunction
  function automatic logic [31:0] mem_word(input logic [31:0] idx, input int k);
    logic [31:0] t [5] = '{77, 10, 11, 12, 13};
    return (idx == 3) ? t[k] : (idx * 32'h9E37_79B1) ^ (32'(k) * 32'h85EB_CA6B) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [D*32-1:0] rnd_vec();
    logic [D*32-1:0] v;
    for (int k = 0; k < D; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction
  task automatic run_req(input logic [31:0] idx, input int mode, input bit hold, input int abort_at);
    bit hit, done, cmd_done;
    logic [31:0] edoc;
    logic [D*32-1:0] evec;
    int n, lat, bi, stores, cmds, rdc, rdw, rspw;
    @(negedge clk);
    rsp_ready = 0;
    mem_rsp_valid = 0;
    mem_rd_ready = 0;
    hit = c_doc.exists(idx);
    edoc = hit ? c_doc[idx] : mem_word(idx, 0);
    if (hit) evec = c_vec[idx];
    else for (int k = 1; k <= D; k++) evec[32*(k-1) +: 32] = mem_word(idx, k);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1;
    req_idx = idx;
    cache_hit = hit;
    cache_doc_idx = hit ? edoc : $urandom;
    cache_vector = hit ? evec : rnd_vec();
    @(posedge clk);
    #1 req_valid = hold;
    if (hit) m_hit = sat(m_hit);
    else m_miss = sat(m_miss);
    rdw = (mode == 1) ? 3 : 0;
    rspw = (mode == 1) ? 4 : 0;
    n = 0; lat = 0; bi = 0; stores = 0; cmds = 0; rdc = 0; done = 0; cmd_done = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      chk("req_ready_busy", req_ready, 0);
      if (cache_store) begin
        stores++;
        chk("store_idx", cache_store_idx, idx);
        chk("store_doc", cache_store_doc_idx, edoc);
        chk("store_vec", cache_store_vector, evec);
        c_doc[idx] = edoc;
        c_vec[idx] = evec;
      end
      if (mem_rd_valid) begin
        rdc++;
        chk("mem_rd_addr", mem_rd_addr, BASE + idx * REC);
      end
      if (rsp_valid) begin
        if (lat == 0) lat = n;
        chk("rsp_idx", rsp_idx, idx);
        chk("rsp_doc", rsp_doc_idx, edoc);
        chk("rsp_vec", rsp_vector, evec);
        chk("rsp_from_cache", rsp_from_cache, hit);
      end
      if (abort_at > 0 && bi == abort_at) begin
        rst_n = 0;
        #1;
        chk_reset("abort");
        chk("abort_no_store", stores, 0);
        m_hit = 0;
        m_miss = 0;
        return;
      end
      if (n >= 2 && !hit && mode == 2) cache_hit = 1'($urandom_range(0, 1));
      mem_rsp_valid = cmd_done && bi <= D &&
        ((mode == 1) ? (n % 2 == 0) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
      mem_rsp_data = mem_rsp_valid ? mem_word(idx, bi) : $urandom;
      if (mem_rsp_valid && mem_rsp_ready) bi++;
      mem_rd_ready = 0;
      if (mem_rd_valid) begin
        if (rdw > 0) rdw--;
        else mem_rd_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_rd_ready) begin
          cmds++;
          cmd_done = 1;
        end
      end
      rsp_ready = 0;
      if (rsp_valid) begin
        if (rspw > 0) rspw--;
        else rsp_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        done = rsp_ready;
      end
    end
    chk("rsp_handshake_in_budget", done, 1);
    chk("store_count", stores, hit ? 0 : 1);
    chk("mem_cmd_count", cmds, hit ? 0 : 1);
    chk("mem_rd_seen", rdc != 0, !hit);
    if (mode == 0) chk("rsp_latency", lat, hit ? 2 : 5 + D);
    chk("hit_count", hit_count, m_hit);
    chk("miss_count", miss_count, m_miss);
  endtask
  initial begin
    rst_n = 0;
    req_valid = 0; req_idx = 0; cache_hit = 0; cache_vector = '0; cache_doc_idx = 0;
    mem_rd_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; rsp_ready = 0;
    c_doc[5] = 9;
    c_vec[5] = rnd_vec();
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst_n = 1;
    run_req(3, 0, 0, 0);
    chk("cold_miss_addr_const", BASE + 3 * REC, 32'h103C);
    run_req(5, 0, 0, 0);
    c_doc.delete(3);
    c_vec.delete(3);
    run_req(3, 1, 0, 0);
    run_req(6, 0, 0, 3);
    @(negedge clk);
    rst_n = 1;
    chk_reset("post_abort");
    run_req(1, 0, 0, 0);
    run_req(2, 0, 1, 0);
    run_req(2, 0, 0, 0);
    @(negedge clk);
    force dut.hit_count = 32'hFFFF_FFFE;
    #1 release dut.hit_count;
    m_hit = 32'hFFFF_FFFE;
    repeat (3) run_req(2, 0, 0, 0);
    chk("hit_count_saturated", hit_count, 32'hFFFF_FFFF);
    for (int i = 0; i < 25; i++) begin
      logic [31:0] ridx;
      ridx = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) begin
        c_doc.delete(ridx);
        c_vec.delete(ridx);
      end
      run_req(ridx, 2, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
